// File: rtl/cicero_job_sequencer.sv
// cicero_job_sequencer: host-side sequencer for the regex coprocessor
// register interface. It writes program/data words to the engine BRAM and
// launches jobs. For each job it reads back the elapsed-cycle count, rearms
// the engine, and hands one result to the host.
// Optional feature macro: CICERO_SEQ_TIMEOUT_EN (RUN watchdog + S_KILL path).
module cicero_job_sequencer #(
  parameter int REG_WIDTH      = 32,
  parameter int REG_WIDTH_64   = 64,
  parameter int ADDR_WIDTH     = 9,
  parameter int TIMEOUT_CYCLES = 1 << 20
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [ADDR_WIDTH-1:0]   load_addr,
  input  logic [REG_WIDTH_64-1:0] load_data,
  input  logic                    job_valid,
  output logic                    job_ready,
  input  logic [REG_WIDTH-1:0]    job_start_cc,
  input  logic [REG_WIDTH-1:0]    job_end_cc,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic                    res_accept,
  output logic                    res_error,
  output logic                    res_timeout,
  output logic [REG_WIDTH-1:0]    res_elapsed,
  output logic [REG_WIDTH-1:0]    cmd_register,
  output logic [REG_WIDTH-1:0]    address_register,
  output logic [REG_WIDTH_64-1:0] data_in_register,
  output logic [REG_WIDTH-1:0]    start_cc_pointer_register,
  output logic [REG_WIDTH-1:0]    end_cc_pointer_register,
  input  logic [REG_WIDTH-1:0]    status_register,
  input  logic [REG_WIDTH_64-1:0] data_o_register
);

  localparam logic [REG_WIDTH-1:0] CMD_NOP                = REG_WIDTH'(0);
  localparam logic [REG_WIDTH-1:0] CMD_WRITE              = REG_WIDTH'(1);
  localparam logic [REG_WIDTH-1:0] CMD_START              = REG_WIDTH'(2);
  localparam logic [REG_WIDTH-1:0] CMD_RESET              = REG_WIDTH'(3);
  localparam logic [REG_WIDTH-1:0] CMD_RESTART            = REG_WIDTH'(4);
  localparam logic [REG_WIDTH-1:0] CMD_READ_ELAPSED_CLOCK = REG_WIDTH'(5);

  localparam logic [REG_WIDTH-1:0] STATUS_IDLE     = REG_WIDTH'(0);
  localparam logic [REG_WIDTH-1:0] STATUS_RUNNING  = REG_WIDTH'(1);
  localparam logic [REG_WIDTH-1:0] STATUS_ACCEPTED = REG_WIDTH'(2);
  localparam logic [REG_WIDTH-1:0] STATUS_REJECTED = REG_WIDTH'(3);
  localparam logic [REG_WIDTH-1:0] STATUS_ERROR    = REG_WIDTH'(4);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_START, S_RUN, S_READCC, S_RESTART, S_RESULT, S_KILL
  } state_t;

  state_t                  state_q, state_d;
  logic [REG_WIDTH-1:0]    cmd_d, addr_d, start_d, end_d, elapsed_d;
  logic [REG_WIDTH_64-1:0] data_d;
  logic                    res_valid_d, accept_d, error_d, timeout_d;
  logic                    idle_ok, terminal;

  assign idle_ok  = (status_register == STATUS_IDLE);
  // Unknown status codes fall outside this set, so S_RUN keeps waiting
  assign terminal = (status_register == STATUS_ACCEPTED) ||
                    (status_register == STATUS_REJECTED) ||
                    (status_register == STATUS_ERROR);

`ifdef CICERO_SEQ_TIMEOUT_EN
  logic [31:0] run_cnt_q, run_cnt_d, run_cnt_inc;
  assign run_cnt_inc = run_cnt_q + 32'd1;
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYCLES != 0);
`endif

  logic unused_rd;
  assign unused_rd = ^data_o_register[REG_WIDTH_64-1:REG_WIDTH];

  // Next-state, handshake and next-register computation
  always_comb begin
    state_d     = state_q;
    cmd_d       = CMD_NOP;
    addr_d      = address_register;
    data_d      = data_in_register;
    start_d     = start_cc_pointer_register;
    end_d       = end_cc_pointer_register;
    elapsed_d   = res_elapsed;
    res_valid_d = res_valid;
    accept_d    = res_accept;
    error_d     = res_error;
    timeout_d   = res_timeout;
    load_ready  = 1'b0;
    job_ready   = 1'b0;
`ifdef CICERO_SEQ_TIMEOUT_EN
    run_cnt_d   = run_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (idle_ok) begin
          load_ready = load_valid;
          job_ready  = job_valid & ~load_valid;
          if (load_valid) begin
            cmd_d   = CMD_WRITE;
            addr_d  = {{(REG_WIDTH-ADDR_WIDTH){1'b0}}, load_addr};
            data_d  = load_data;
            state_d = S_WRITE;
          end else if (job_valid) begin
            cmd_d   = CMD_START;
            start_d = job_start_cc;
            end_d   = job_end_cc;
            state_d = S_START;
          end
        end
      end
      S_WRITE: state_d = S_IDLE;
      S_START: begin
        if (status_register == STATUS_RUNNING) begin
          state_d = S_RUN;
`ifdef CICERO_SEQ_TIMEOUT_EN
          run_cnt_d = 32'd0;
`endif
        end else begin
          cmd_d = CMD_START;
        end
      end
      S_RUN: begin
`ifdef CICERO_SEQ_TIMEOUT_EN
        run_cnt_d = run_cnt_inc;
`endif
        if (terminal) begin
          accept_d  = (status_register == STATUS_ACCEPTED);
          error_d   = (status_register == STATUS_ERROR);
          timeout_d = 1'b0;
          cmd_d     = CMD_READ_ELAPSED_CLOCK;
          state_d   = S_READCC;
        end
`ifdef CICERO_SEQ_TIMEOUT_EN
        else if (run_cnt_inc == 32'(TIMEOUT_CYCLES)) begin
          accept_d  = 1'b0;
          error_d   = 1'b1;
          timeout_d = 1'b1;
          elapsed_d = REG_WIDTH'(run_cnt_inc);
          cmd_d     = CMD_RESET;
          state_d   = S_KILL;
        end
`endif
      end
      S_READCC: begin
        elapsed_d = data_o_register[REG_WIDTH-1:0];
        cmd_d     = CMD_RESTART;
        state_d   = S_RESTART;
      end
      S_RESTART: begin
        if (idle_ok) begin
          res_valid_d = 1'b1;
          state_d     = S_RESULT;
        end else begin
          cmd_d = CMD_RESTART;
        end
      end
      S_RESULT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
`ifdef CICERO_SEQ_TIMEOUT_EN
      // Engine was hard-reset; rearm and wait for IDLE like a normal job
      S_KILL: begin
        cmd_d   = CMD_RESTART;
        state_d = S_RESTART;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // State and all registered outputs; synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q                   <= S_IDLE;
      cmd_register              <= CMD_NOP;
      address_register          <= '0;
      data_in_register          <= '0;
      start_cc_pointer_register <= '0;
      end_cc_pointer_register   <= '0;
      res_valid                 <= 1'b0;
      res_accept                <= 1'b0;
      res_error                 <= 1'b0;
      res_timeout               <= 1'b0;
      res_elapsed               <= '0;
`ifdef CICERO_SEQ_TIMEOUT_EN
      run_cnt_q                 <= 32'd0;
`endif
    end else begin
      state_q                   <= state_d;
      cmd_register              <= cmd_d;
      address_register          <= addr_d;
      data_in_register          <= data_d;
      start_cc_pointer_register <= start_d;
      end_cc_pointer_register   <= end_d;
      res_valid                 <= res_valid_d;
      res_accept                <= accept_d;
      res_error                 <= error_d;
      res_timeout               <= timeout_d;
      res_elapsed               <= elapsed_d;
`ifdef CICERO_SEQ_TIMEOUT_EN
      run_cnt_q                 <= run_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_cicero_job_sequencer.sv
// Directed bench for cicero_job_sequencer with a small behavioural engine.
// The timeout scenario runs only when CICERO_SEQ_TIMEOUT_EN is defined.
module tb_cicero_job_sequencer;

  localparam logic [31:0] C_NOP = 0, C_WRITE = 1, C_START = 2, C_RESET = 3,
                          C_RESTART = 4, C_READ = 5;
  localparam logic [31:0] ST_IDLE = 0, ST_RUNNING = 1, ST_ACCEPTED = 2,
                          ST_REJECTED = 3, ST_ERROR = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_valid = 1'b0, job_valid = 1'b0, res_ready = 1'b0;
  logic [8:0]  load_addr = '0;
  logic [63:0] load_data = '0;
  logic [31:0] job_start_cc = '0, job_end_cc = '0;
  logic        load_ready, job_ready, res_valid, res_accept, res_error, res_timeout;
  logic [31:0] res_elapsed, cmd_register, address_register;
  logic [31:0] start_cc_pointer_register, end_cc_pointer_register;
  logic [63:0] data_in_register, data_o_register;
  logic [31:0] status_register;

  int n_tests = 0;
  int n_fail  = 0;

  // engine model controls
  logic [31:0] eng_status = ST_IDLE;
  logic [31:0] eng_cnt = '0;
  logic        eng_rst = 1'b1;
  logic        never_finish = 1'b0;
  int          run_len = 40;
  logic [31:0] final_status = ST_ACCEPTED;

  always #5 clk = ~clk;

  cicero_job_sequencer #(.TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_valid(load_valid), .load_ready(load_ready), .load_addr(load_addr), .load_data(load_data),
    .job_valid(job_valid), .job_ready(job_ready), .job_start_cc(job_start_cc), .job_end_cc(job_end_cc),
    .res_valid(res_valid), .res_ready(res_ready), .res_accept(res_accept), .res_error(res_error),
    .res_timeout(res_timeout), .res_elapsed(res_elapsed),
    .cmd_register(cmd_register), .address_register(address_register), .data_in_register(data_in_register),
    .start_cc_pointer_register(start_cc_pointer_register), .end_cc_pointer_register(end_cc_pointer_register),
    .status_register(status_register), .data_o_register(data_o_register)
  );

  assign status_register = eng_status;
  assign data_o_register = (cmd_register == C_READ) ? {32'hA5A5_A5A5, eng_cnt} : 64'h0;

  // Behavioural engine: START -> RUNNING for run_len cycles -> final_status; RESTART/RESET -> IDLE
  always @(posedge clk) begin
    if (eng_rst) begin
      eng_status <= ST_IDLE;
      eng_cnt    <= 0;
    end else if (cmd_register == C_RESET) begin
      eng_status <= ST_IDLE;
      eng_cnt    <= 0;
    end else if (eng_status == ST_IDLE && cmd_register == C_START) begin
      eng_status <= ST_RUNNING;
      eng_cnt    <= 0;
    end else if (eng_status == ST_RUNNING) begin
      eng_cnt <= eng_cnt + 1;
      if (!never_finish && (eng_cnt + 1 == 32'(run_len))) eng_status <= final_status;
    end else if (cmd_register == C_RESTART && eng_status != ST_IDLE) begin
      eng_status <= ST_IDLE;
    end
  end

  // Runs cycles until res_valid, tallying commands seen; no checks here
  task automatic collect(input int budget, output int n_start, output int n_read,
                         output int n_restart, output int n_kill, output bit ok);
    n_start = 0; n_read = 0; n_restart = 0; n_kill = 0; ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (cmd_register == C_START)   n_start++;
      if (cmd_register == C_READ)    n_read++;
      if (cmd_register == C_RESTART) n_restart++;
      if (cmd_register == C_RESET)   n_kill++;
      if (res_valid) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  // Presents one job at an idle negedge; returns whether it was accepted
  task automatic issue_job(input logic [31:0] s, input logic [31:0] e, output logic acc);
    job_start_cc = s; job_end_cc = e; job_valid = 1'b1;
    #1 acc = job_ready;
    @(negedge clk);
    job_valid = 1'b0;
  endtask

  task automatic release_result();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; eng_rst = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if (cmd_register !== C_NOP) begin n_fail++; $display("FAIL reset_cmd got %0d want %0d", cmd_register, C_NOP); end
    n_tests++;
    if ({address_register, data_in_register, start_cc_pointer_register, end_cc_pointer_register, res_elapsed} !== '0) begin
      n_fail++; $display("FAIL reset_regs got nonzero addr=%0h data=%0h elapsed=%0h", address_register, data_in_register, res_elapsed);
    end
    n_tests++;
    if ({res_valid, res_accept, res_error, res_timeout, load_ready, job_ready} !== 6'b0) begin
      n_fail++; $display("FAIL reset_flags got %b want 000000", {res_valid, res_accept, res_error, res_timeout, load_ready, job_ready});
    end
    rst_n = 1'b1; eng_rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_load();
    load_addr = 9'd5; load_data = 64'hDEAD_BEEF_0123_4567; load_valid = 1'b1;
    #1;
    n_tests++;
    if (load_ready !== 1'b1) begin n_fail++; $display("FAIL load_ready got %b want 1", load_ready); end
    @(negedge clk);
    load_valid = 1'b0;
    n_tests++;
    if (cmd_register !== C_WRITE) begin n_fail++; $display("FAIL load_cmd got %0d want %0d", cmd_register, C_WRITE); end
    n_tests++;
    if (address_register !== 32'd5) begin n_fail++; $display("FAIL load_addr got %0d want 5", address_register); end
    n_tests++;
    if (data_in_register !== 64'hDEAD_BEEF_0123_4567) begin n_fail++; $display("FAIL load_data got %h want deadbeef01234567", data_in_register); end
    @(negedge clk);
    n_tests++;
    if (cmd_register !== C_NOP) begin n_fail++; $display("FAIL load_cmd_after got %0d want %0d", cmd_register, C_NOP); end
  endtask

  task automatic test_job();
    logic acc; int ns, nr, nrs, nk; bit ok;
    run_len = 40; final_status = ST_ACCEPTED; never_finish = 1'b0;
    issue_job(32'd0, 32'd16, acc);
    n_tests++;
    if (acc !== 1'b1) begin n_fail++; $display("FAIL job_ready got %b want 1", acc); end
    n_tests++;
    if ({start_cc_pointer_register, end_cc_pointer_register} !== {32'd0, 32'd16}) begin
      n_fail++; $display("FAIL job_ptrs got %0d/%0d want 0/16", start_cc_pointer_register, end_cc_pointer_register);
    end
    collect(200, ns, nr, nrs, nk, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL job_done got no result want res_valid within 200 cycles"); end
    n_tests++;
    if (ns !== 2) begin n_fail++; $display("FAIL job_start_cycles got %0d want 2", ns); end
    n_tests++;
    if (nr !== 1 || nrs < 1) begin n_fail++; $display("FAIL job_read_restart got read=%0d restart=%0d want 1/>=1", nr, nrs); end
    n_tests++;
    if ({res_accept, res_error, res_timeout} !== 3'b100) begin n_fail++; $display("FAIL job_flags got %b want 100", {res_accept, res_error, res_timeout}); end
    n_tests++;
    if (res_elapsed !== 32'd40) begin n_fail++; $display("FAIL job_elapsed got %0d want 40", res_elapsed); end
    n_tests++;
    if (cmd_register !== C_NOP) begin n_fail++; $display("FAIL job_result_cmd got %0d want 0", cmd_register); end
    release_result();
    n_tests++;
    if (res_valid !== 1'b0) begin n_fail++; $display("FAIL job_res_drop got %b want 0", res_valid); end
  endtask

  task automatic test_priority();
    int ns, nr, nrs, nk; bit ok;
    run_len = 8; final_status = ST_REJECTED;
    load_addr = 9'd9; load_data = 64'h1; load_valid = 1'b1;
    job_start_cc = 32'd3; job_end_cc = 32'd7; job_valid = 1'b1;
    #1;
    n_tests++;
    if ({load_ready, job_ready} !== 2'b10) begin n_fail++; $display("FAIL prio_ready got %b want 10", {load_ready, job_ready}); end
    @(negedge clk);
    load_valid = 1'b0;
    n_tests++;
    if (cmd_register !== C_WRITE || address_register !== 32'd9) begin
      n_fail++; $display("FAIL prio_write got cmd=%0d addr=%0d want 1/9", cmd_register, address_register);
    end
    n_tests++;
    if (job_ready !== 1'b0) begin n_fail++; $display("FAIL prio_job_in_write got %b want 0", job_ready); end
    @(negedge clk);
    n_tests++;
    if (job_ready !== 1'b1) begin n_fail++; $display("FAIL prio_job_next got %b want 1", job_ready); end
    @(negedge clk);
    job_valid = 1'b0;
    n_tests++;
    if (cmd_register !== C_START || start_cc_pointer_register !== 32'd3) begin
      n_fail++; $display("FAIL prio_start got cmd=%0d start=%0d want 2/3", cmd_register, start_cc_pointer_register);
    end
    collect(200, ns, nr, nrs, nk, ok);
    n_tests++;
    if (!ok || {res_accept, res_error} !== 2'b00 || res_elapsed !== 32'd8) begin
      n_fail++; $display("FAIL prio_reject got ok=%0d acc/err=%b elapsed=%0d want 1/00/8", ok, {res_accept, res_error}, res_elapsed);
    end
    release_result();
  endtask

  task automatic test_error_hold();
    logic acc; int ns, nr, nrs, nk; bit ok;
    run_len = 12; final_status = ST_ERROR;
    issue_job(32'd1, 32'd2, acc);
    collect(200, ns, nr, nrs, nk, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL err_done got no result want res_valid"); end
    load_valid = 1'b1; job_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      n_tests++;
      if ({res_valid, res_error, res_accept, load_ready, job_ready} !== 5'b11000 || res_elapsed !== 32'd12) begin
        n_fail++; $display("FAIL err_hold[%0d] got %b elapsed=%0d want 11000/12", i,
                           {res_valid, res_error, res_accept, load_ready, job_ready}, res_elapsed);
      end
      @(negedge clk);
    end
    load_valid = 1'b0; res_ready = 1'b1;
    #1;
    n_tests++;
    if ({load_ready, job_ready} !== 2'b00) begin n_fail++; $display("FAIL err_same_cycle got %b want 00", {load_ready, job_ready}); end
    @(negedge clk);
    res_ready = 1'b0;
    #1;
    n_tests++;
    if ({res_valid, job_ready} !== 2'b01) begin n_fail++; $display("FAIL err_after got %b want 01", {res_valid, job_ready}); end
    job_valid = 1'b0;
    @(negedge clk);
  endtask

`ifdef CICERO_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    logic acc; int ns, nr, nrs, nk; bit ok;
    never_finish = 1'b1;
    issue_job(32'd0, 32'd4, acc);
    collect(400, ns, nr, nrs, nk, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL tmo_done got no result want res_valid"); end
    n_tests++;
    if (nk !== 1) begin n_fail++; $display("FAIL tmo_reset_cycles got %0d want 1", nk); end
    n_tests++;
    if ({res_timeout, res_error, res_accept} !== 3'b110 || res_elapsed !== 32'd100) begin
      n_fail++; $display("FAIL tmo_flags got %b elapsed=%0d want 110/100", {res_timeout, res_error, res_accept}, res_elapsed);
    end
    never_finish = 1'b0;
    release_result();
  endtask
`endif

  task automatic test_reset_mid_run();
    logic acc;
    never_finish = 1'b1;
    issue_job(32'd5, 32'd6, acc);
    repeat (20) @(negedge clk);
    n_tests++;
    if (status_register !== ST_RUNNING) begin n_fail++; $display("FAIL rst_run_setup got %0d want 1", status_register); end
    rst_n = 1'b0; load_valid = 1'b1; job_valid = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    n_tests++;
    if ({cmd_register, res_valid, load_ready, job_ready} !== {C_NOP, 3'b000}) begin
      n_fail++; $display("FAIL rst_run_out got cmd=%0d flags=%b want 0/000", cmd_register, {res_valid, load_ready, job_ready});
    end
    n_tests++;
    if (start_cc_pointer_register !== 32'd0) begin n_fail++; $display("FAIL rst_run_ptr got %0d want 0", start_cc_pointer_register); end
    repeat (3) @(negedge clk);
    n_tests++;
    if ({load_ready, job_ready} !== 2'b00) begin n_fail++; $display("FAIL rst_busy_ready got %b want 00", {load_ready, job_ready}); end
    eng_rst = 1'b1; never_finish = 1'b0;
    @(negedge clk);
    eng_rst = 1'b0;
    #1;
    n_tests++;
    if ({load_ready, job_ready, res_valid} !== 3'b100) begin
      n_fail++; $display("FAIL rst_idle_ready got %b want 100", {load_ready, job_ready, res_valid});
    end
    load_valid = 1'b0; job_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_load();
    test_job();
    test_priority();
    test_error_hold();
`ifdef CICERO_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
